inst_execute: RTL and testbench
===============================

Name: inst_execute

Overview:
- RV64 integer execute stage, directly downstream of the instruction decode stage; consumes its operand/control bundle.
- Computes ALU results, which become load addresses for loads.
- Resolves conditional branches and registers everything for the memory/write-back stage.
- Squashes the younger in-flight instructions after a taken branch.

Parameters:
- SQUASH_CYCLES, 2: number of incoming instructions turned into bubbles after a taken branch; legal range 1..7.
- XLEN, 64: datapath width; only 64 is supported.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- rd, rs1, rs2  in  5 each  register indices from decode.
- funct3  in  3  operation/condition selector.
- funct7  in  7  R-type modifier.
- op1, op2  in  64 each  operands; op2 is the sign-extended immediate when imm_flag=1.
- write_back, imm_flag, mem_acc, load_flag, word_inst, branch_flag  in  1 each  decode control bits.
- branch_offset  in  64  sign-extended B-immediate.
- PC_i  in  64  PC of the instruction being executed.
- alu_result  out  64  registered result or load address.
- rd_o  out  5  registered rd.
- funct3_o  out  3  registered funct3; gives the load size to the memory stage.
- write_back_o, mem_acc_o, load_flag_o  out  1 each  registered controls.
- branch_taken  out  1  one-cycle pulse for a resolved taken branch.
- branch_target  out  64  PC_i + branch_offset; valid while branch_taken=1.
- flush  out  1  high while in SQUASH; upstream stages must discard fetched/decoded state.

Behaviour:
- Reset: every output is 0 and state is RUN, asynchronously. Reset mid-squash returns to RUN and clears the counter.
- Latency: inputs are sampled on posedge CLK; outputs are valid one cycle later. No backpressure: one instruction per cycle.
- ALU by funct3:
  - 000: add; sub when imm_flag=0 and funct7[5]=1.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when the select bit is 1. The select bit is funct7[5] for register ops and op2[10] for immediate ops.
  - 110: or.
  - 111: and.
- Shift amount: op2[5:0] normally; op2[4:0] when word_inst=1.
- word_inst=1: operate on op1[31:0]/op2[31:0] and sign-extend bit 31 of the 32-bit result to 64 bits. sra.w shifts the sign of op1[31].
- Load (load_flag=1): alu_result = op1 + op2, full 64-bit, funct3 ignored for the ALU.
- Branch (branch_flag=1):
  - Conditions by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Funct3 010/011 are never taken.
  - Branch outputs: write_back_o=0, mem_acc_o=0, alu_result=0.
- State machine:
  - RUN: a non-squashed taken branch sets branch_taken<=1 and branch_target<=PC_i+branch_offset (modulo 2^64, wrap allowed). It then moves to SQUASH with cnt<=SQUASH_CYCLES.
  - SQUASH: each incoming instruction is a bubble: write_back_o=0, mem_acc_o=0, load_flag_o=0, rd_o=0, alu_result=0, and branch_flag is ignored. cnt decrements each cycle; the state returns to RUN on the edge where cnt==1.
- flush equals (state==SQUASH). branch_taken is high for exactly one cycle per taken branch.
- A branch arriving in the final SQUASH cycle is squashed. A branch in the first RUN cycle afterwards executes normally.

Optional Feature:
- Macro: EXEC_FORWARD_EN.
- Defined: EX->EX bypass. If the previous registered write_back_o=1, load_flag_o=0, rd_o!=0 and rd_o==rs1, then alu_result replaces op1. The same rule replaces op2 with alu_result when rs2 matches and imm_flag=0 and the instruction is not a load.
- Bypass is never taken from a squashed bubble.
- Not defined: op1/op2 are used exactly as received. Software/scheduling must then guarantee one-instruction separation.

Decomposition:
- Shared package rv_pkg:
  - opcode constants;
  - ALU funct3 codes (ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND);
  - branch funct3 codes (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - state encoding (RUN, SQUASH).
- One combinational sub-module, alu64: op1, op2, funct3, alt-bit and word inputs -> 64-bit result. Branch compare, squash FSM and output registers stay in inst_execute.

Test Plan:
- Arithmetic: add op1=0x7FFFFFFF, op2=1, word_inst=1 -> alu_result=0xFFFFFFFF80000000. Same inputs with word_inst=0 -> 0x0000000080000000.
- Immediate shift: sra imm, op1=0x8000000000000000, op2=0x403 (bit10=1, shamt 3) -> 0xF000000000000000. With op2=0x003 -> 0x1000000000000000.
- Branch: blt op1=-1, op2=1, PC_i=0x1000, offset=-16 -> branch_taken=1 for one cycle, target=0xFF0, flush high 2 cycles. The next two instructions come out with write_back_o=0.
- Squash edge: taken beq followed by a second taken beq in the squash window -> second ignored, single branch_taken pulse. bltu op1=1, op2=-1 -> taken.
- Forwarding (EXEC_FORWARD_EN): addi x5=0+7, then add x6=x5+x5 with stale op1=op2=0 -> alu_result=14. Without the macro -> 0.
- Reset: assert reset during SQUASH with branch_taken=1 -> all outputs 0 immediately, flush=0. The first instruction after release executes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV64 definitions for the execute-stage slice.
// Contents: major opcode constants, ALU funct3 codes, branch funct3 codes,
// and the execute-stage squash state type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

  localparam logic [2:0] ADD_SUB = 3'b000;
  localparam logic [2:0] SLL     = 3'b001;
  localparam logic [2:0] SLT     = 3'b010;
  localparam logic [2:0] SLTU    = 3'b011;
  localparam logic [2:0] XOR     = 3'b100;
  localparam logic [2:0] SRL_SRA = 3'b101;
  localparam logic [2:0] OR      = 3'b110;
  localparam logic [2:0] AND     = 3'b111;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } exec_state_e;

endpackage

// File: rtl/alu64.sv
// Combinational RV64 integer ALU.
// Ports:
//   op1, op2  : operands (op2 low bits give the shift amount)
//   funct3    : operation select (ADD_SUB .. AND)
//   alt       : sub for ADD_SUB, arithmetic shift for SRL_SRA
//   word      : 32-bit operation, result sign-extended from bit 31
//   result    : 64-bit result
module alu64
  import rv_pkg::*;
(
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic        word,
  output logic [63:0] result
);

  logic [5:0]  sh64;
  logic [4:0]  sh32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [63:0] sra64;
  logic [31:0] sra32;
  logic [63:0] r64;
  logic [31:0] r32;

  assign sh64 = op2[5:0];
  assign sh32 = op2[4:0];
  assign a32  = op1[31:0];
  assign b32  = op2[31:0];

  // Arithmetic shifts kept as standalone assignments so the signed context
  // is not lost by mixing with unsigned operands in a conditional.
  assign sra64 = $signed(op1) >>> sh64;
  assign sra32 = $signed(a32) >>> sh32;

  always_comb begin
    r64 = '0;
    case (funct3)
      ADD_SUB: r64 = alt ? (op1 - op2) : (op1 + op2);
      SLL:     r64 = op1 << sh64;
      SLT:     r64 = {63'd0, $signed(op1) < $signed(op2)};
      SLTU:    r64 = {63'd0, op1 < op2};
      XOR:     r64 = op1 ^ op2;
      SRL_SRA: r64 = alt ? sra64 : (op1 >> sh64);
      OR:      r64 = op1 | op2;
      AND:     r64 = op1 & op2;
      default: r64 = '0;
    endcase
  end

  always_comb begin
    r32 = '0;
    case (funct3)
      ADD_SUB: r32 = alt ? (a32 - b32) : (a32 + b32);
      SLL:     r32 = a32 << sh32;
      SLT:     r32 = {31'd0, $signed(a32) < $signed(b32)};
      SLTU:    r32 = {31'd0, a32 < b32};
      XOR:     r32 = a32 ^ b32;
      SRL_SRA: r32 = alt ? sra32 : (a32 >> sh32);
      OR:      r32 = a32 | b32;
      AND:     r32 = a32 & b32;
      default: r32 = '0;
    endcase
  end

  assign result = word ? {{32{r32[31]}}, r32} : r64;

endmodule

// File: rtl/inst_execute.sv
// RV64 integer execute stage: ALU / load-address generation, conditional
// branch resolution, squash of younger instructions after a taken branch,
// and registered outputs for the memory/write-back stage.
// Optional build macro: EXEC_FORWARD_EN (EX->EX bypass from the previous
// registered result).
// Ports:
//   CLK, reset (async, active-low)
//   rd, rs1, rs2, funct3, funct7, op1, op2, control bits, branch_offset, PC_i
//     : decode bundle
//   alu_result, rd_o, funct3_o, write_back_o, mem_acc_o, load_flag_o
//     : registered results/controls to memory stage
//   branch_taken, branch_target : one-cycle taken-branch redirect
//   flush : high while squashing; upstream discards its state
module inst_execute
  import rv_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned XLEN          = 64
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            write_back,
  input  logic            imm_flag,
  input  logic            mem_acc,
  input  logic            load_flag,
  input  logic            word_inst,
  input  logic            branch_flag,
  input  logic [XLEN-1:0] branch_offset,
  input  logic [XLEN-1:0] PC_i,
  output logic [XLEN-1:0] alu_result,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            write_back_o,
  output logic            mem_acc_o,
  output logic            load_flag_o,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            flush
);

  exec_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [XLEN-1:0] src1, src2;
  logic [XLEN-1:0] alu_out;
  logic            alt_sel;
  logic            br_cond;

  logic [XLEN-1:0] res_d, tgt_d;
  logic [4:0]      rd_d;
  logic [2:0]      f3_d;
  logic            wb_d, mem_d, ld_d, bt_d;

  logic            unused_inputs;
  assign unused_inputs = ^{rs1, rs2, funct7[6], funct7[4:0]};

`ifdef EXEC_FORWARD_EN
  // A bubble always registers write_back_o=0, so it can never be a source.
  logic fwd_ok;
  always_comb begin
    fwd_ok = write_back_o && !load_flag_o && (rd_o != '0);
    src1   = (fwd_ok && (rd_o == rs1)) ? alu_result : op1;
    src2   = (fwd_ok && (rd_o == rs2) && !imm_flag && !load_flag) ? alu_result : op2;
  end
`else
  assign src1 = op1;
  assign src2 = op2;
`endif

  // Shift type comes from imm[10] for immediates; funct7[5] only selects
  // sub for register ops.
  assign alt_sel = (funct3 == SRL_SRA) ? (imm_flag ? op2[10] : funct7[5])
                                       : (!imm_flag && funct7[5]);

  alu64 u_alu (
    .op1    (src1),
    .op2    (src2),
    .funct3 (funct3),
    .alt    (alt_sel),
    .word   (word_inst),
    .result (alu_out)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      BEQ:     br_cond = (src1 == src2);
      BNE:     br_cond = (src1 != src2);
      BLT:     br_cond = ($signed(src1) <  $signed(src2));
      BGE:     br_cond = ($signed(src1) >= $signed(src2));
      BLTU:    br_cond = (src1 <  src2);
      BGEU:    br_cond = (src1 >= src2);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = load_flag ? (src1 + src2) : alu_out;
    rd_d    = rd;
    f3_d    = funct3;
    wb_d    = write_back;
    mem_d   = mem_acc;
    ld_d    = load_flag;
    bt_d    = 1'b0;
    tgt_d   = branch_target;
    case (state_q)
      RUN: begin
        if (branch_flag) begin
          res_d = '0;
          wb_d  = 1'b0;
          mem_d = 1'b0;
          if (br_cond) begin
            bt_d    = 1'b1;
            tgt_d   = PC_i + branch_offset;
            state_d = SQUASH;
            cnt_d   = 3'(SQUASH_CYCLES);
          end
        end
      end
      SQUASH: begin
        res_d = '0;
        rd_d  = '0;
        wb_d  = 1'b0;
        mem_d = 1'b0;
        ld_d  = 1'b0;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      alu_result    <= '0;
      rd_o          <= '0;
      funct3_o      <= '0;
      write_back_o  <= 1'b0;
      mem_acc_o     <= 1'b0;
      load_flag_o   <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_result    <= res_d;
      rd_o          <= rd_d;
      funct3_o      <= f3_d;
      write_back_o  <= wb_d;
      mem_acc_o     <= mem_d;
      load_flag_o   <= ld_d;
      branch_taken  <= bt_d;
      branch_target <= tgt_d;
    end
  end

  assign flush = (state_q == SQUASH);

endmodule

// File: tb/tb_inst_execute.sv
// Self-checking bench for inst_execute: directed vector table, hand-written
// branch/squash/reset/bypass sequences, and randomized traffic against a
// behavioural model.
module tb_inst_execute;

  localparam int unsigned SQ = 2;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] op1, op2, branch_offset, PC_i;
  logic        write_back, imm_flag, mem_acc, load_flag, word_inst, branch_flag;
  logic [63:0] alu_result, branch_target;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic        write_back_o, mem_acc_o, load_flag_o, branch_taken, flush;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  inst_execute #(.SQUASH_CYCLES(SQ), .XLEN(64)) dut (
    .CLK(CLK), .reset(reset),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .op1(op1), .op2(op2),
    .write_back(write_back), .imm_flag(imm_flag), .mem_acc(mem_acc),
    .load_flag(load_flag), .word_inst(word_inst), .branch_flag(branch_flag),
    .branch_offset(branch_offset), .PC_i(PC_i),
    .alu_result(alu_result), .rd_o(rd_o), .funct3_o(funct3_o),
    .write_back_o(write_back_o), .mem_acc_o(mem_acc_o), .load_flag_o(load_flag_o),
    .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0;
    op1 = '0; op2 = '0; branch_offset = '0; PC_i = '0;
    write_back = 0; imm_flag = 0; mem_acc = 0; load_flag = 0;
    word_inst = 0; branch_flag = 0;
  endtask

  task automatic alu_op(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic imm, input logic word, input logic ld,
                        input logic wb, input logic [4:0] rdv,
                        input logic [4:0] r1, input logic [4:0] r2);
    nop();
    funct3 = f3; funct7 = f7; op1 = a; op2 = b;
    imm_flag = imm; word_inst = word; load_flag = ld; mem_acc = ld;
    write_back = wb; rd = rdv; rs1 = r1; rs2 = r2;
  endtask

  task automatic br(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] pc, input logic [63:0] off);
    nop();
    branch_flag = 1; funct3 = f3; op1 = a; op2 = b; PC_i = pc; branch_offset = off;
  endtask

  // Reference ALU: plain integer arithmetic on 64-bit or 32-bit values.
  function automatic logic [63:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic imm, input logic word, input logic ld);
    logic        is_sub, is_sra;
    longint      sa, sb;
    int          wa, wbv;
    logic [31:0] r32;
    logic [63:0] r;
    is_sub = !imm && f7[5];
    is_sra = imm ? b[10] : f7[5];
    if (ld) return a + b;
    if (word) begin
      wa = a[31:0]; wbv = b[31:0]; r32 = '0;
      case (f3)
        3'd0: r32 = is_sub ? wa - wbv : wa + wbv;
        3'd1: r32 = a[31:0] << b[4:0];
        3'd2: r32 = (wa < wbv) ? 32'd1 : 32'd0;
        3'd3: r32 = (a[31:0] < b[31:0]) ? 32'd1 : 32'd0;
        3'd4: r32 = a[31:0] ^ b[31:0];
        3'd5: if (is_sra) r32 = wa >>> b[4:0]; else r32 = a[31:0] >> b[4:0];
        3'd6: r32 = a[31:0] | b[31:0];
        default: r32 = a[31:0] & b[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b; r = '0;
    case (f3)
      3'd0: r = is_sub ? a - b : a + b;
      3'd1: r = a << b[5:0];
      3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: if (is_sra) r = sa >>> b[5:0]; else r = a >> b[5:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic ref_br(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a, b;
    logic        imm, word, ld;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          pulses;
    logic [63:0] fwd_exp;
    int          sl;
    logic [63:0] prev_res;
    logic [4:0]  prev_rd;
    logic        prev_wb, prev_ld;

    vecs.push_back('{3'd0, 7'h00, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFF80000000});
    vecs.push_back('{3'd0, 7'h00, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'h0000000080000000});
    vecs.push_back('{3'd5, 7'h00, 64'h8000000000000000, 64'h403, 1'b1, 1'b0, 1'b0, 64'hF000000000000000});
    vecs.push_back('{3'd5, 7'h00, 64'h8000000000000000, 64'h003, 1'b1, 1'b0, 1'b0, 64'h1000000000000000});
    vecs.push_back('{3'd0, 7'h20, 64'd5, 64'd7, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE});
    vecs.push_back('{3'd0, 7'h20, 64'd5, 64'd7, 1'b1, 1'b0, 1'b0, 64'd12});
    vecs.push_back('{3'd1, 7'h00, 64'd1, 64'h41, 1'b0, 1'b0, 1'b0, 64'd2});
    vecs.push_back('{3'd1, 7'h00, 64'd1, 64'h3F, 1'b0, 1'b0, 1'b0, 64'h8000000000000000});
    vecs.push_back('{3'd1, 7'h00, 64'd1, 64'h21, 1'b0, 1'b1, 1'b0, 64'd2});
    vecs.push_back('{3'd2, 7'h00, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'd1});
    vecs.push_back('{3'd3, 7'h00, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0});
    vecs.push_back('{3'd4, 7'h00, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 1'b0, 1'b0, 1'b0, 64'h0FF00FF00FF00FF0});
    vecs.push_back('{3'd6, 7'h00, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 1'b0, 1'b0, 1'b0, 64'hFFF0FFF0FFF0FFF0});
    vecs.push_back('{3'd7, 7'h00, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 1'b0, 1'b0, 1'b0, 64'hF000F000F000F000});
    vecs.push_back('{3'd5, 7'h00, 64'h8000000000000000, 64'd4, 1'b0, 1'b0, 1'b0, 64'h0800000000000000});
    vecs.push_back('{3'd5, 7'h20, 64'h0000000080000000, 64'd4, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFF8000000});
    vecs.push_back('{3'd5, 7'h00, 64'h0000000080000000, 64'd4, 1'b0, 1'b1, 1'b0, 64'h0000000008000000});
    vecs.push_back('{3'd3, 7'h00, 64'h1000, 64'hFFFFFFFFFFFFFFF8, 1'b1, 1'b1, 1'b1, 64'h0000000000000FF8});
    vecs.push_back('{3'd0, 7'h20, 64'hFFFFFFFF00000000, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF});

    // Reset state
    reset = 1'b1;
    nop();
    #3 reset = 1'b0;
    #1;
    chk("reset alu_result", alu_result, 64'd0);
    chk("reset rd_o", {59'd0, rd_o}, 64'd0);
    chk("reset ctrl", {58'd0, funct3_o, write_back_o, mem_acc_o, load_flag_o}, 64'd0);
    chk("reset branch_taken", {63'd0, branch_taken}, 64'd0);
    chk("reset flush", {63'd0, flush}, 64'd0);
    chk("reset branch_target", branch_target, 64'd0);
    #8 reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      alu_op(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].word,
             vecs[i].ld, 1'b1, 5'(i + 1), 5'd0, 5'd0);
      step();
      chk($sformatf("vec%0d alu_result", i), alu_result, vecs[i].exp);
      chk($sformatf("vec%0d rd_o", i), {59'd0, rd_o}, 64'(i + 1));
      chk($sformatf("vec%0d flags", i), {61'd0, write_back_o, mem_acc_o, load_flag_o},
          {61'd0, 1'b1, vecs[i].ld, vecs[i].ld});
    end

    // Taken blt, two squashed followers, then normal execution
    br(3'd4, '1, 64'd1, 64'h1000, -64'sd16);
    step();
    chk("blt branch_taken", {63'd0, branch_taken}, 64'd1);
    chk("blt branch_target", branch_target, 64'hFF0);
    chk("blt flush", {63'd0, flush}, 64'd1);
    chk("blt write_back_o", {63'd0, write_back_o}, 64'd0);
    chk("blt alu_result", alu_result, 64'd0);
    alu_op(3'd0, 7'h00, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0);
    step();
    chk("sq1 branch_taken", {63'd0, branch_taken}, 64'd0);
    chk("sq1 flush", {63'd0, flush}, 64'd1);
    chk("sq1 bubble", {alu_result[58:0], rd_o, write_back_o}, 65'd0);
    step();
    chk("sq2 flush", {63'd0, flush}, 64'd0);
    chk("sq2 bubble", {alu_result[58:0], rd_o, write_back_o}, 65'd0);
    step();
    chk("post-squash alu_result", alu_result, 64'd3);
    chk("post-squash wb/rd", {58'd0, write_back_o, rd_o}, {58'd0, 1'b1, 5'd7});

    // Second taken branch inside the squash window is ignored
    pulses = 0;
    br(3'd0, 64'd5, 64'd5, 64'h2000, 64'h40);
    step();
    pulses += int'(branch_taken);
    chk("beq1 branch_target", branch_target, 64'h2040);
    nop();
    step();
    pulses += int'(branch_taken);
    br(3'd0, 64'd5, 64'd5, 64'h3000, 64'h80);
    step();
    pulses += int'(branch_taken);
    chk("beq2 flush", {63'd0, flush}, 64'd0);
    chk("single pulse", 64'(pulses), 64'd1);
    br(3'd6, 64'd1, '1, 64'h4000, 64'd8);
    step();
    chk("bltu branch_taken", {63'd0, branch_taken}, 64'd1);
    chk("bltu branch_target", branch_target, 64'h4008);
    nop();
    step();
    step();

    // Reset asserted mid-squash
    br(3'd0, 64'd0, 64'd0, 64'h5000, 64'd4);
    step();
    chk("pre-reset branch_taken", {63'd0, branch_taken}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("midreset outputs", {alu_result[49:0], rd_o, funct3_o, write_back_o, mem_acc_o,
                             load_flag_o, branch_taken, flush}, 64'd0);
    chk("midreset branch_target", branch_target, 64'd0);
    @(negedge CLK);
    reset = 1'b1;
    alu_op(3'd0, 7'h00, 64'd10, 64'd20, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 5'd0);
    step();
    chk("after reset alu_result", alu_result, 64'd30);
    chk("after reset wb/flush", {62'd0, write_back_o, flush}, 64'd2);

    // Back-to-back dependency
    alu_op(3'd0, 7'h00, 64'd0, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0);
    step();
    chk("addi x5", alu_result, 64'd7);
    alu_op(3'd0, 7'h00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd5, 5'd5);
    step();
`ifdef EXEC_FORWARD_EN
    fwd_exp = 64'd14;
`else
    fwd_exp = 64'd0;
`endif
    chk("dependent add", alu_result, fwd_exp);

    // Randomized traffic against the model
    nop();
    step();
    sl = 0; prev_res = '0; prev_rd = '0; prev_wb = 0; prev_ld = 0;
    for (int n = 0; n < 400; n++) begin
      int          kind;
      logic [63:0] ea, eb, e_res, e_tgt;
      logic [4:0]  e_rd;
      logic        e_wb, e_mem, e_ld, e_bt, bubble;
      nop();
      kind   = $urandom_range(0, 7);
      rd     = 5'($urandom_range(0, 7));
      rs1    = 5'($urandom_range(0, 7));
      rs2    = 5'($urandom_range(0, 7));
      funct3 = 3'($urandom);
      funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      op1    = rnd64();
      op2    = rnd64();
      PC_i   = rnd64();
      branch_offset = $urandom_range(0, 1) ? rnd64() : 64'(signed'(12'($urandom)));
      if (kind < 2) begin
        branch_flag = 1;
        if ($urandom_range(0, 1) == 1) op2 = op1;
      end else if (kind == 2) begin
        load_flag = 1; mem_acc = 1; imm_flag = 1; write_back = 1;
      end else begin
        imm_flag   = 1'($urandom_range(0, 1));
        word_inst  = 1'($urandom_range(0, 1));
        write_back = ($urandom_range(0, 3) != 0);
      end

      ea = op1; eb = op2;
`ifdef EXEC_FORWARD_EN
      if (prev_wb && !prev_ld && prev_rd != 0) begin
        if (prev_rd == rs1) ea = prev_res;
        if (prev_rd == rs2 && !imm_flag && !load_flag) eb = prev_res;
      end
`endif
      bubble = 0; e_bt = 0; e_tgt = '0;
      if (sl > 0) begin
        bubble = 1; e_res = '0; e_rd = '0; e_wb = 0; e_mem = 0; e_ld = 0;
        sl--;
      end else if (branch_flag) begin
        e_res = '0; e_rd = rd; e_wb = 0; e_mem = 0; e_ld = load_flag;
        e_bt = ref_br(funct3, ea, eb);
        if (e_bt) begin
          e_tgt = PC_i + branch_offset;
          sl = SQ;
        end
      end else begin
        e_res = ref_alu(funct3, funct7, ea, eb, imm_flag, word_inst, load_flag);
        e_rd = rd; e_wb = write_back; e_mem = mem_acc; e_ld = load_flag;
      end

      step();
      chk($sformatf("rnd%0d alu_result", n), alu_result, e_res);
      chk($sformatf("rnd%0d ctrl", n),
          {56'd0, rd_o, write_back_o, mem_acc_o, load_flag_o},
          {56'd0, e_rd, e_wb, e_mem, e_ld});
      chk($sformatf("rnd%0d taken/flush", n), {62'd0, branch_taken, flush},
          {62'd0, e_bt, sl > 0});
      if (e_bt) chk($sformatf("rnd%0d branch_target", n), branch_target, e_tgt);
      if (!bubble) chk($sformatf("rnd%0d funct3_o", n), {61'd0, funct3_o}, {61'd0, funct3});
      prev_res = e_res; prev_rd = e_rd; prev_wb = e_wb; prev_ld = e_ld;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
